// File: rtl/alu_control_sequencer.sv
// Control sequencer for the fetch / 3-register ALU execute loop (T0..T5).
// It drives the data_path enables and reads back only the IR and the memory-ready flag.
module alu_control_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int OP_WIDTH       = 5,
    parameter int ALU_OP_MAX     = 11,
    parameter int HALT_OP        = 31,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  stop_req,
    input  logic [DATA_WIDTH-1:0] ir_in,
    input  logic                  mem_ready,
    output logic                  PCout,
    output logic                  PCin,
    output logic                  IncPC,
    output logic                  MARin,
    output logic                  Read,
    output logic                  MDRin,
    output logic                  MDRout,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  Zin,
    output logic                  Zlowout,
    output logic [NUM_REGS-1:0]   Rin,
    output logic [NUM_REGS-1:0]   Rout,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic                  busy,
    output logic                  halted,
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  instr_count,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_HALT = 4'd7
    } state_t;

    localparam int OP_LSB = DATA_WIDTH - OP_WIDTH;
    localparam logic [REG_ADDR_WIDTH:0] REG_LIMIT = (REG_ADDR_WIDTH + 1)'(NUM_REGS);

    state_t cur_state;
    state_t nxt_state;
    logic   t1_wait;   // high in T1 cycles after the first, so PC is loaded only once

    // IR fields: opcode on top, then ra, rb, rc packed directly below it
    logic [OP_WIDTH-1:0]       op;
    logic [REG_ADDR_WIDTH-1:0] ra;
    logic [REG_ADDR_WIDTH-1:0] rb;
    logic [REG_ADDR_WIDTH-1:0] rc;
    logic                      is_halt;
    logic                      is_bad;

    assign op = ir_in[DATA_WIDTH-1 -: OP_WIDTH];
    assign ra = ir_in[OP_LSB-1 -: REG_ADDR_WIDTH];
    assign rb = ir_in[OP_LSB-REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
    assign rc = ir_in[OP_LSB-2*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];

    assign is_halt = (op == OP_WIDTH'(HALT_OP));
    assign is_bad  = (op > OP_WIDTH'(ALU_OP_MAX))
                   | ({1'b0, ra} >= REG_LIMIT)
                   | ({1'b0, rb} >= REG_LIMIT)
                   | ({1'b0, rc} >= REG_LIMIT);

    function automatic logic [NUM_REGS-1:0] one_hot(input logic [REG_ADDR_WIDTH-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Next-state logic: free-running instruction loop, HALT is left only through clear
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:  if (start) nxt_state = S_T0;
            S_T0:    nxt_state = S_T1;
            S_T1:    if (mem_ready) nxt_state = S_T2;
            S_T2:    nxt_state = S_T3;
            S_T3:    nxt_state = (is_halt || is_bad) ? S_HALT : S_T4;
            S_T4:    nxt_state = S_T5;
            S_T5:    nxt_state = stop_req ? S_IDLE : S_T0;
            S_HALT:  nxt_state = S_HALT;
            default: nxt_state = S_IDLE;
        endcase
    end

    // State register, T1 wait flag, sticky illegal flag and retired-instruction counter
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (clear) begin
            cur_state   <= S_IDLE;
            t1_wait     <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            cur_state <= nxt_state;
            t1_wait   <= (cur_state == S_T1) && (nxt_state == S_T1);
            if (cur_state == S_T3 && !is_halt && is_bad) illegal <= 1'b1;
            if (cur_state == S_T5) instr_count <= instr_count + CNT_WIDTH'(1);
        end
    end

    // Moore strobe decode from the state register and the held IR contents
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Rin     = '0;
        Rout    = '0;
        alu_op  = '0;
        case (cur_state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (!t1_wait) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (!is_halt && !is_bad) begin
                    Rout = one_hot(rb);
                    Yin  = 1'b1;
                end
            end
            S_T4: begin
                Rout   = one_hot(rc);
                Zin    = 1'b1;
                alu_op = op;
            end
            S_T5: begin
                Zlowout = 1'b1;
                Rin     = one_hot(ra);
            end
            default: ;
        endcase
    end

    assign busy   = (cur_state != S_IDLE) && (cur_state != S_HALT);
    assign halted = (cur_state == S_HALT);
    assign state  = cur_state;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Self-checking bench: cycle-level model of the instruction loop plus directed literal checks.
module tb_alu_control_sequencer;

    logic        clk;
    logic        clear, start, stop_req, mem_ready;
    logic [31:0] ir_in;

    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;
    logic        busy, halted, illegal;
    logic [15:0] instr_count;
    logic [3:0]  state;

    // Second instance: 8 registers, 3-bit counter (exercises register bound and counter wrap)
    logic        d2_PCout, d2_PCin, d2_IncPC, d2_MARin, d2_Read, d2_MDRin, d2_MDRout, d2_IRin;
    logic        d2_Yin, d2_Zin, d2_Zlowout;
    logic [7:0]  d2_Rin, d2_Rout;
    logic [4:0]  d2_alu_op;
    logic        d2_busy, d2_halted, d2_illegal;
    logic [2:0]  d2_instr_count;
    logic [3:0]  d2_state;

    int checks = 0;
    int errors = 0;

    alu_control_sequencer dut (
        .Clock(clk), .clear(clear), .start(start), .stop_req(stop_req), .ir_in(ir_in),
        .mem_ready(mem_ready), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .busy(busy),
        .halted(halted), .illegal(illegal), .instr_count(instr_count), .state(state)
    );

    alu_control_sequencer #(.NUM_REGS(8), .CNT_WIDTH(3)) dut2 (
        .Clock(clk), .clear(clear), .start(start), .stop_req(stop_req), .ir_in(ir_in),
        .mem_ready(mem_ready), .PCout(d2_PCout), .PCin(d2_PCin), .IncPC(d2_IncPC),
        .MARin(d2_MARin), .Read(d2_Read), .MDRin(d2_MDRin), .MDRout(d2_MDRout),
        .IRin(d2_IRin), .Yin(d2_Yin), .Zin(d2_Zin), .Zlowout(d2_Zlowout), .Rin(d2_Rin),
        .Rout(d2_Rout), .alu_op(d2_alu_op), .busy(d2_busy), .halted(d2_halted),
        .illegal(d2_illegal), .instr_count(d2_instr_count), .state(d2_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (state codes: IDLE0 T0..T5=1..6 HALT7) ----------------
    typedef struct packed {
        logic pc_out, pc_in, inc_pc, mar_in, rd, mdr_in, mdr_out, ir_ld, y_in, z_in, zlow_out;
    } strobes_t;

    int m_state = 0;
    bit m_first = 1'b1;
    bit m_illegal = 1'b0;
    int m_count = 0;
    bit m_valid = 1'b0;

    function automatic bit legal_instr(input logic [31:0] ir);
        int op, ra, rb, rc;
        op = int'(ir >> 27);
        ra = int'((ir >> 23) & 32'hF);
        rb = int'((ir >> 19) & 32'hF);
        rc = int'((ir >> 15) & 32'hF);
        return (op <= 11) && (ra < 16) && (rb < 16) && (rc < 16);
    endfunction

    task automatic model_step();
        if (clear) begin
            m_state = 0; m_first = 1'b1; m_illegal = 1'b0; m_count = 0; m_valid = 1'b1;
            return;
        end
        case (m_state)
            0: if (start) m_state = 1;
            1: begin m_state = 2; m_first = 1'b1; end
            2: if (mem_ready) m_state = 3; else m_first = 1'b0;
            3: m_state = 4;
            4: begin
                if ((ir_in >> 27) == 31) m_state = 7;
                else if (!legal_instr(ir_in)) begin m_state = 7; m_illegal = 1'b1; end
                else m_state = 5;
            end
            5: m_state = 6;
            6: begin m_count = (m_count + 1) % 65536; m_state = stop_req ? 0 : 1; end
            default: ;
        endcase
    endtask

    task automatic compare();
        strobes_t es, as;
        logic [15:0] e_rin, e_rout;
        logic [4:0]  e_op;
        int ra, rb, rc;
        ra = int'((ir_in >> 23) & 32'hF);
        rb = int'((ir_in >> 19) & 32'hF);
        rc = int'((ir_in >> 15) & 32'hF);
        es = '0; e_rin = '0; e_rout = '0; e_op = '0;
        case (m_state)
            1: begin es.pc_out = 1; es.mar_in = 1; es.inc_pc = 1; es.z_in = 1; end
            2: begin
                es.rd = 1; es.mdr_in = 1;
                if (m_first) begin es.pc_in = 1; es.zlow_out = 1; end
            end
            3: begin es.mdr_out = 1; es.ir_ld = 1; end
            4: if ((ir_in >> 27) != 31 && legal_instr(ir_in)) begin
                es.y_in = 1; e_rout = 16'(1 << rb);
            end
            5: begin es.z_in = 1; e_rout = 16'(1 << rc); e_op = ir_in[31:27]; end
            6: begin es.zlow_out = 1; e_rin = 16'(1 << ra); end
            default: ;
        endcase
        as = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout};
        check("strobes", 32'(as), 32'(es));
        check("Rin", 32'(Rin), 32'(e_rin));
        check("Rout", 32'(Rout), 32'(e_rout));
        check("alu_op", 32'(alu_op), 32'(e_op));
        check("state", 32'(state), m_state);
        check("busy_halted_illegal", {29'd0, busy, halted, illegal},
              {29'd0, (m_state != 0 && m_state != 7), (m_state == 7), m_illegal});
        check("instr_count", 32'(instr_count), m_count);
    endtask

    // Single compare process: advance the model on each edge, then check the settled outputs
    always begin
        @(posedge clk);
        model_step();
        #2;
        if (m_valid) compare();
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        int n_pcin, n_read, irin_at;
        clear = 1'b1; start = 1'b0; stop_req = 1'b0; ir_in = '0; mem_ready = 1'b1;
        cyc(); cyc();
        check("rst_state", 32'(state), 0);
        check("rst_count", 32'(instr_count), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_rout", 32'(Rout), 0);
        clear = 1'b0;

        // Nominal R1 <= R2 op5 R3
        ir_in = 32'h28918000; start = 1'b1;
        cyc(); start = 1'b0;
        check("t0_pcout", 32'(PCout), 1);
        cyc(); cyc(); cyc();
        check("t3_rout", 32'(Rout), 32'h0004);
        check("t3_yin", 32'(Yin), 1);
        cyc();
        check("t4_rout", 32'(Rout), 32'h0008);
        check("t4_alu_op", 32'(alu_op), 5);
        check("t4_zin", 32'(Zin), 1);
        cyc();
        check("t5_rin", 32'(Rin), 32'h0002);
        check("t5_rout", 32'(Rout), 0);
        cyc();
        check("count_after_1", 32'(instr_count), 1);
        check("loop_back_t0", 32'(state), 1);
        stop_req = 1'b1;
        repeat (6) cyc();
        check("stop_idle", 32'(state), 0);
        check("count_after_2", 32'(instr_count), 2);
        stop_req = 1'b0;

        // clear in the middle of T4
        start = 1'b1; cyc(); start = 1'b0;
        repeat (4) cyc();
        check("midrun_in_t4", 32'(state), 5);
        clear = 1'b1; cyc();
        check("midrun_state", 32'(state), 0);
        check("midrun_rout", 32'(Rout), 0);
        check("midrun_zin", 32'(Zin), 0);
        check("midrun_count", 32'(instr_count), 0);
        clear = 1'b0;

        // Three wait states in T1
        mem_ready = 1'b0; start = 1'b1;
        n_pcin = 0; n_read = 0; irin_at = -1;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            if (PCin) n_pcin++;
            if (Read && MDRin) n_read++;
            if (IRin) irin_at = i;
            if (i == 1) start = 1'b0;
            if (i == 5) mem_ready = 1'b1;
            if (i == 8) stop_req = 1'b1;
        end
        check("wait_pcin_cycles", n_pcin, 1);
        check("wait_read_cycles", n_read, 4);
        check("wait_irin_cycle", irin_at, 6);
        cyc();
        check("wait_idle", 32'(state), 0);
        check("wait_count", 32'(instr_count), 1);
        stop_req = 1'b0;

        // Halt opcode
        ir_in = 32'hF8000000; start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        check("halt_t3_busy", 32'(busy), 1);
        check("halt_t3_yin", 32'(Yin), 0);
        cyc();
        check("halt_halted", 32'(halted), 1);
        check("halt_busy", 32'(busy), 0);
        for (int k = 0; k < 3; k++) begin
            start = 1'b1; cyc(); start = 1'b0; cyc();
        end
        check("halt_sticky", 32'(state), 7);
        check("halt_count", 32'(instr_count), 1);
        check("halt_not_illegal", 32'(illegal), 0);

        // Illegal opcode 12
        clear = 1'b1; cyc(); clear = 1'b0;
        ir_in = 32'h60918000; start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        check("illop_t3_rout", 32'(Rout), 0);
        cyc();
        check("illop_halted", 32'(halted), 1);
        check("illop_illegal", 32'(illegal), 1);
        check("illop_rout", 32'(Rout), 0);

        // rc=9: legal with 16 registers, illegal with 8
        clear = 1'b1; cyc(); clear = 1'b0;
        ir_in = 32'h28948000; start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        check("rc9_d2_t3_rout", 32'(d2_Rout), 0);
        check("rc9_t3_rout", 32'(Rout), 32'h0004);
        stop_req = 1'b1;
        cyc();
        check("rc9_d2_illegal", 32'(d2_illegal), 1);
        check("rc9_d2_halted", 32'(d2_halted), 1);
        check("rc9_legal_in_t4", 32'(state), 5);
        check("rc9_not_illegal", 32'(illegal), 0);
        cyc(); cyc();
        check("rc9_idle", 32'(state), 0);
        stop_req = 1'b0;

        // Three back-to-back instructions, stop raised during the third T2
        clear = 1'b1; cyc(); clear = 1'b0;
        ir_in = 32'h28918000; start = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            cyc();
            if (i == 1) start = 1'b0;
            if (i == 15) stop_req = 1'b1;
        end
        check("loop3_idle", 32'(state), 0);
        check("loop3_count", 32'(instr_count), 3);
        check("loop3_d2_count", 32'(d2_instr_count), 3);
        stop_req = 1'b0;

        // Five more: the 3-bit counter wraps 7 -> 0
        start = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            cyc();
            if (i == 1) start = 1'b0;
            if (i == 25) check("wrap_d2_at_max", 32'(d2_instr_count), 7);
            if (i == 27) stop_req = 1'b1;
        end
        check("wrap_idle", 32'(state), 0);
        check("wrap_d2_count", 32'(d2_instr_count), 0);
        check("wrap_count", 32'(instr_count), 8);
        stop_req = 1'b0;

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
